// File: rtl/counter_pkg.sv
// Shared constants for the counting primitives.
//   DIR_UP / DIR_DN    : values of the up_dn control input
//   MODE_WRAP/MODE_SAT : values of the SATURATE parameter
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;

  localparam bit   MODE_WRAP = 1'b0;
  localparam bit   MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/count_next.sv
// Combinational next-count calculator for updown_counter_n.
// Parameters: WIDTH, MAX_COUNT (upper bound), SATURATE (wrap/hold at bounds).
// Ports:
//   i_q        in  WIDTH  current count
//   i_up_dn    in  1      direction (DIR_UP / DIR_DN)
//   o_next     out WIDTH  count after one enabled step
//   o_at_bound out 1      current count sits at the bound for this direction
//   o_wrap_evt out 1      the step wraps around the modulus
module count_next
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1,
  parameter bit               SATURATE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_next,
  output logic             o_at_bound,
  output logic             o_wrap_evt
);

  logic w_up;
  logic w_at_bound;

  assign w_up       = (i_up_dn == DIR_UP);
  assign w_at_bound = w_up ? (i_q == MAX_COUNT) : (i_q == '0);
  assign o_at_bound = w_at_bound;

  // Away from the bound a plain WIDTH-bit +/-1 never leaves 0..MAX_COUNT,
  // so the modulus only matters at the bound itself.
  always_comb begin
    o_next     = i_q;
    o_wrap_evt = 1'b0;
    if (!w_at_bound) begin
      o_next = w_up ? (i_q + WIDTH'(1)) : (i_q - WIDTH'(1));
    end else if (SATURATE == MODE_WRAP) begin
      o_next     = w_up ? '0 : MAX_COUNT;
      o_wrap_evt = 1'b1;
    end
  end

endmodule : count_next

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with wrap or saturate behaviour.
// Parameters: WIDTH (2..32), MAX_COUNT (1..2**WIDTH-1), SATURATE (0 wrap, 1 hold).
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      asynchronous active-high reset
//   clear    in  1      synchronous clear of count and status
//   load     in  1      synchronous load of load_val (clamped to MAX_COUNT)
//   load_val in  WIDTH  value to load
//   en       in  1      count enable
//   up_dn    in  1      1 = up, 0 = down
//   Qout     out WIDTH  registered count
//   tc       out 1      combinational terminal count for the current direction
//   wrap     out 1      registered one-cycle wrap pulse
//   ovf      out 1      registered sticky overflow/underflow flag
// Priority per edge: reset > clear > load > en.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1,
  parameter bit               SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] Qout,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next;
  logic             w_at_bound;
  logic             w_wrap_evt;
  logic [WIDTH-1:0] w_load_clamped;

  count_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_count_next (
    .i_q        (r_q),
    .i_up_dn    (up_dn),
    .o_next     (w_next),
    .o_at_bound (w_at_bound),
    .o_wrap_evt (w_wrap_evt)
  );

  assign w_load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (load) begin
      r_q    <= w_load_clamped;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= w_next;
      r_wrap <= w_wrap_evt;
      // Hitting the bound while enabled is an overflow in both modes.
      if (w_at_bound) begin
        r_ovf <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign Qout = r_q;
  assign wrap = r_wrap;
  assign ovf  = r_ovf;
  assign tc   = w_at_bound;

endmodule : updown_counter_n

// File: tb/tb_updown_counter_n.sv
module tb_updown_counter_n;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset, clear, load, en, up_dn;
  logic [7:0] load_val;

  logic [7:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c, w_a, w_b, w_c, o_a, o_b, o_c;

  // dut 0: 8-bit full range wrap; dut 1: mod 10 wrap; dut 2: mod 10 saturate
  updown_counter_n #(.WIDTH(8)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .Qout(q_a), .tc(tc_a), .wrap(w_a), .ovf(o_a));
  updown_counter_n #(.WIDTH(8), .MAX_COUNT(8'd9), .SATURATE(MODE_WRAP)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .Qout(q_b), .tc(tc_b), .wrap(w_b), .ovf(o_b));
  updown_counter_n #(.WIDTH(8), .MAX_COUNT(8'd9), .SATURATE(MODE_SAT)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .Qout(q_c), .tc(tc_c), .wrap(w_c), .ovf(o_c));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: count as a plain integer in 0..max
  int mx [3] = '{255, 9, 9};
  bit ms [3] = '{1'b0, 1'b0, 1'b1};
  int mq [3];
  bit mw [3];
  bit mo [3];

  function automatic logic [10:0] obs_vec(int k);
    case (k)
      0:       return {q_a, w_a, o_a, tc_a};
      1:       return {q_b, w_b, o_b, tc_b};
      default: return {q_c, w_c, o_c, tc_c};
    endcase
  endfunction

  function automatic logic [10:0] exp_vec(int k);
    bit t;
    t = up_dn ? (mq[k] == mx[k]) : (mq[k] == 0);
    return {8'(mq[k]), mw[k], mo[k], t};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; mw[k] = 1'b0; mo[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    int t;
    if (reset || clear) begin
      mq[k] = 0; mw[k] = 1'b0; mo[k] = 1'b0;
    end else if (load) begin
      mq[k] = (int'(load_val) > mx[k]) ? mx[k] : int'(load_val);
      mw[k] = 1'b0;
    end else if (en) begin
      t = mq[k] + (up_dn ? 1 : -1);
      if (t < 0 || t > mx[k]) begin
        mo[k] = 1'b1;
        if (ms[k]) mw[k] = 1'b0;
        else begin
          mq[k] = (t + mx[k] + 1) % (mx[k] + 1);
          mw[k] = 1'b1;
        end
      end else begin
        mq[k] = t;
        mw[k] = 1'b0;
      end
    end else begin
      mw[k] = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] g, e;
    reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up_dn = DIR_UP; load_val = '0;
    #2;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      up_dn = (d == 0) ? DIR_UP : DIR_DN;
      #1;
      for (int k = 0; k < 3; k++) begin
        g = obs_vec(k); e = exp_vec(k); n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL reset dut%0d up=%b got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   k, up_dn, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
      end
    end
    @(negedge clk);
    reset = 1'b0; up_dn = DIR_UP;
  endtask

  task automatic test_count_up();
    logic [10:0] g, e;
    en = 1'b1; up_dn = DIR_UP;
    for (int i = 1; i <= 256; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        g = obs_vec(k); e = exp_vec(k); n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL count_up dut%0d step%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   k, i, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
      end
      if (i == 255) begin
        n_cmp++;
        if (q_a !== 8'd255 || tc_a !== 1'b1 || w_a !== 1'b0) begin
          n_err++;
          $display("FAIL count_up_top got q=%0d tc=%b w=%b want 255/1/0", q_a, tc_a, w_a);
        end
      end
      if (i == 256) begin
        n_cmp++;
        if (q_a !== 8'd0 || w_a !== 1'b1 || o_a !== 1'b1) begin
          n_err++;
          $display("FAIL count_up_wrap got q=%0d w=%b o=%b want 0/1/1", q_a, w_a, o_a);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_mod();
    logic [10:0] g, e;
    clear = 1'b1; tick(); clear = 1'b0;
    en = 1'b1; up_dn = DIR_DN;
    for (int i = 1; i <= 22; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        g = obs_vec(k); e = exp_vec(k); n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL down_mod dut%0d step%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   k, i, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (q_b !== 8'd9 || w_b !== 1'b1) begin
          n_err++;
          $display("FAIL down_underflow got q=%0d w=%b want 9/1", q_b, w_b);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_load();
    logic [10:0] g, e;
    clear = 1'b1; tick(); clear = 1'b0;
    load = 1'b1; load_val = 8'd7; tick(); load = 1'b0;
    en = 1'b1; up_dn = DIR_UP;
    for (int i = 1; i <= 5; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        g = obs_vec(k); e = exp_vec(k); n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL sat_load dut%0d step%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   k, i, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
      end
      n_cmp++;
      if (w_c !== 1'b0 || o_c !== (i >= 3)) begin
        n_err++;
        $display("FAIL sat_hold step%0d got w=%b o=%b want 0/%b", i, w_c, o_c, (i >= 3));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    logic [10:0] g, e;
    load = 1'b1; load_val = 8'd5; tick();
    clear = 1'b1; load_val = 8'd200; en = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      g = obs_vec(k); e = exp_vec(k); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL prio_clear dut%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                 k, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
      end
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      g = obs_vec(k); e = exp_vec(k); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL prio_load dut%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                 k, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
      end
    end
    n_cmp++;
    if (q_b !== 8'd9 || q_a !== 8'd200) begin
      n_err++;
      $display("FAIL load_clamp got q_b=%0d q_a=%0d want 9/200", q_b, q_a);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [10:0] g, e;
    load = 1'b1; load_val = 8'd100; tick(); load = 1'b0;
    en = 1'b1; up_dn = DIR_UP; tick();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      g = obs_vec(k); e = exp_vec(k); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL async_reset dut%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                 k, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
      end
    end
    #2;
    reset = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      g = obs_vec(k); e = exp_vec(k); n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL after_reset dut%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                 k, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
      end
    end
    n_cmp++;
    if (q_a !== 8'd1) begin
      n_err++;
      $display("FAIL resume got q=%0d want 1", q_a);
    end
    en = 1'b0;
  endtask

  task automatic test_toggle();
    logic [10:0] g, e;
    clear = 1'b1; tick(); clear = 1'b0;
    load = 1'b1; load_val = 8'd4; tick(); load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up_dn = (i % 2 == 0) ? DIR_UP : DIR_DN;
      tick();
      for (int k = 0; k < 3; k++) begin
        g = obs_vec(k); e = exp_vec(k); n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL toggle dut%0d step%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   k, i, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
      end
      n_cmp++;
      if (q_b !== ((i % 2 == 0) ? 8'd5 : 8'd4) || w_b !== 1'b0 || o_b !== 1'b0) begin
        n_err++;
        $display("FAIL toggle_seq step%0d got q=%0d w=%b o=%b want %0d/0/0",
                 i, q_b, w_b, o_b, (i % 2 == 0) ? 5 : 4);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    logic [10:0] g, e;
    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(31) == 0);
      load     = ($urandom_range(15) == 0);
      load_val = 8'($urandom_range(255));
      en       = ($urandom_range(3) != 0);
      up_dn    = 1'($urandom_range(1));
      tick();
      for (int k = 0; k < 3; k++) begin
        g = obs_vec(k); e = exp_vec(k); n_cmp++;
        if (g !== e) begin
          n_err++;
          $display("FAIL random dut%0d step%0d got q/w/o/tc=%0d/%b/%b/%b want %0d/%b/%b/%b",
                   k, i, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
        end
      end
    end
    clear = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_mod();
    test_sat_load();
    test_priority();
    test_async_reset();
    test_toggle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule : tb_updown_counter_n
